// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the LSU data-memory responder: size codes, FSM states
// and the byte-lane enable helper.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Word RAM with byte-enable write and registered read. A read of the word being
// written in the same cycle returns the freshly written lanes.
module dmem_ram_be #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Array contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we && i_be[b]) mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      for (int b = 0; b < 4; b++)
        o_rdata[8*b +: 8] <= (i_we && i_be[b] && (i_waddr == i_raddr)) ?
                             i_wdata[8*b +: 8] : mem[i_raddr][8*b +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// LSU data-memory responder: byte-lane-masked stores, fixed-latency loads
// shifted to the LSBs, and error reporting for bad size/alignment/range.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_read,
  input  logic [31:0] i_read_addr,
  input  logic        i_write,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [1:0]  i_size,
  output logic        o_ready,
  output logic [31:0] o_read_data,
  output logic        o_rd_valid,
  output logic        o_err
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  state_t            state, state_nx;
  logic [1:0]        cnt;
  logic              rd_acc, wr_acc, go_resp;
  logic [ADDR_W-1:0] cap_word, src_word;
  logic [1:0]        cap_off, cap_size, src_off, src_size;
  logic              cap_err, src_err, wr_err;
  logic [1:0]        resp_off, resp_size;
  logic              resp_err;
  logic [31:0]       ram_rdata, wr_lanes, rd_shift;

  function automatic logic acc_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == SZ_RSVD) || (sz == SZ_HALF && a[0]) ||
           (sz == SZ_WORD && a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    o_ready    = 1'b0;
    o_rd_valid = 1'b0;
    rd_acc     = 1'b0;
    wr_acc     = 1'b0;
    go_resp    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        wr_acc  = i_write;
        rd_acc  = i_read;
        if (i_read) begin
          if (RD_LAT > 1) state_nx = WAIT;
          else begin
            state_nx = RESP;
            go_resp  = 1'b1;
          end
        end
      end
      WAIT: if (cnt == LAST_WAIT) begin
        state_nx = RESP;
        go_resp  = 1'b1;
      end
      RESP: begin
        o_rd_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // RAM is read on the edge entering RESP, from the live request when
  // RD_LAT=1 or from the captured one otherwise.
  assign src_word = (state == IDLE) ? i_read_addr[ADDR_W+1:2] : cap_word;
  assign src_off  = (state == IDLE) ? i_read_addr[1:0] : cap_off;
  assign src_size = (state == IDLE) ? i_size : cap_size;
  assign src_err  = (state == IDLE) ? acc_err(i_read_addr, i_size) : cap_err;
  assign wr_err   = acc_err(i_wr_addr, i_size);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      o_err     <= 1'b0;
      cap_word  <= '0;
      cap_off   <= '0;
      cap_size  <= '0;
      cap_err   <= 1'b0;
      resp_off  <= '0;
      resp_size <= '0;
      resp_err  <= 1'b0;
    end else begin
      cnt   <= (state == WAIT) ? cnt + 2'd1 : 2'd0;
      o_err <= (wr_acc && wr_err) || (go_resp && src_err);
      if (rd_acc) begin
        cap_word <= i_read_addr[ADDR_W+1:2];
        cap_off  <= i_read_addr[1:0];
        cap_size <= i_size;
        cap_err  <= acc_err(i_read_addr, i_size);
      end
      if (go_resp) begin
        resp_off  <= src_off;
        resp_size <= src_size;
        resp_err  <= src_err;
      end
    end
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: wr_lanes = {4{i_wr_data[7:0]}};
      SZ_HALF: wr_lanes = {2{i_wr_data[15:0]}};
      default: wr_lanes = i_wr_data;
    endcase
  end

  dmem_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (wr_acc && !wr_err),
    .i_be    (lane_be(i_size, i_wr_addr[1:0])),
    .i_waddr (i_wr_addr[ADDR_W+1:2]),
    .i_wdata (wr_lanes),
    .i_re    (go_resp),
    .i_raddr (src_word),
    .o_rdata (ram_rdata)
  );

  // Output is derived from registers only updated on RESP entry, so it holds.
  assign rd_shift = ram_rdata >> {resp_off, 3'b000};

  always_comb begin
    o_read_data = rd_shift;
    case (resp_size)
      SZ_BYTE: o_read_data = {24'h0, rd_shift[7:0]};
      SZ_HALF: o_read_data = {16'h0, rd_shift[15:0]};
      default: o_read_data = rd_shift;
    endcase
    if (resp_err) o_read_data = '0;
  end

endmodule
